debounce_multi: RTL and testbench

Parametrised multi-channel push-button conditioner for the board's 50 MHz `clk` domain. It replaces single-button debouncing for the top-level controls. Each channel synchronises a raw button, normalises its polarity and filters bounce with a programmable stability window. It emits a debounced level plus one-cycle press, release and long-press pulses for the game/menu FSMs.

---
 rtl/debounce_multi.sv | 114 +++++++++++
 tb/tb_debounce_multi.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: 2-flop sync, polarity normalise, stability-window debounce, press/release/long pulses.
// Latency: btn_level/btn_press/btn_release move STABLE_CYCLES+2 clk edges after a stable raw change; btn_long LONG_CYCLES cycles after btn_press.
// Backpressure: none; every output pulse is exactly one cycle wide and is never held or queued.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low clear
//   btn_in       raw asynchronous button pins, one per channel
//   btn_level    debounced state per channel, 1 = pressed
//   btn_press    one-cycle pulse when btn_level rises
//   btn_release  one-cycle pulse when btn_level falls
//   btn_long     one-cycle pulse once a press has lasted LONG_CYCLES (0 disables)
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int LONG_CYCLES   = 50000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);

  // Keep the hold counter at least one bit wide so LONG_CYCLES of 0 or 1 still elaborates.
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'((LONG_CYCLES > 0) ? (LONG_CYCLES - 1) : 0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          pressed;
    logic [SW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    assign pressed = s2 ^ ACTIVE_LOW;

    // Synchroniser plus stability window. The counter only advances while the
    // synchronised sample disagrees with the accepted level, so any agreeing
    // sample restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1        <= ACTIVE_LOW;
        s2        <= ACTIVE_LOW;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1        <= btn_in[c];
        s2        <= s1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (pressed != level_q) begin
          if (cnt == SMAX) begin
            level_q   <= ~level_q;
            cnt       <= '0;
            press_q   <= ~level_q;
            release_q <= level_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    if (LONG_CYCLES > 0) begin : g_long
      logic [HW-1:0] hcnt;
      logic          fired;

      // hcnt parks at its terminal value once fired is set; only a release
      // (level back to 0) re-arms the detector, so it never auto-repeats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt   <= '0;
          fired  <= 1'b0;
          long_q <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (!level_q) begin
            hcnt  <= '0;
            fired <= 1'b0;
          end else if (!fired) begin
            if (hcnt == HMAX) begin
              long_q <= 1'b1;
              fired  <= 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
      end
    end else begin : g_no_long
      assign long_q = 1'b0;
    end

    assign btn_level[c]   = level_q;
    assign btn_press[c]   = press_q;
    assign btn_release[c] = release_q;
    assign btn_long[c]    = long_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

  localparam int CH     = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 20;
  localparam int HIST   = STABLE + 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic [CH-1:0] btn_long;

  int vectors;
  int miscompares;

  debounce_multi #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES  (LONG),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: a level flips when the last STABLE synchronised samples
  // (raw values two edges old) all disagree with it; a long pulse is due
  // exactly LONG edges after the press edge while the level is still high.
  logic [CH-1:0] m_level, m_press, m_rel, m_long;
  bit            hist [CH][$];
  int            cyc;
  int            press_cyc [CH];
  bit            lvl, flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc     = 0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int c = 0; c < CH; c++) begin
        press_cyc[c] = 0;
        hist[c].delete();
        for (int k = 0; k < HIST; k++) hist[c].push_back(1'b0);
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        lvl  = m_level[c];
        flip = 1'b1;
        for (int k = 1; k <= STABLE; k++) if (hist[c][k] == lvl) flip = 1'b0;
        m_long[c]  = lvl && ((cyc - press_cyc[c]) == LONG);
        m_press[c] = flip && !lvl;
        m_rel[c]   = flip && lvl;
        if (flip) m_level[c] = !lvl;
        if (flip && !lvl) press_cyc[c] = cyc;
        hist[c].push_front(!btn_in[c]);
        void'(hist[c].pop_back());
      end
      cyc++;
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    btn_in = 2'b00;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_outputs got %b want 00000000", {btn_level, btn_press, btn_release, btn_long});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (btn_press !== ((k == 9) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL reset_repress_pulse edge=%0d got %b want %b", k, btn_press, (k == 9) ? 2'b11 : 2'b00);
      end
      vectors++;
      if (btn_level !== ((k >= 9) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL reset_repress_level edge=%0d got %b want %b", k, btn_level, (k >= 9) ? 2'b11 : 2'b00);
      end
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_reset edge=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
    btn_in = 2'b11;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_reset_settle k=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  task automatic test_clean_press();
    btn_in = 2'b10;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (btn_level[0] !== (k >= 9) || btn_press[0] !== (k == 9)) begin
        miscompares++;
        $display("FAIL clean_press edge=%0d got level=%b press=%b want level=%b press=%b", k, btn_level[0], btn_press[0], k >= 9, k == 9);
      end
      vectors++;
      if ({btn_level[1], btn_press[1], btn_release[1], btn_long[1]} !== 4'b0000) begin
        miscompares++;
        $display("FAIL clean_press_ch1_quiet edge=%0d got %b want 0000", k, {btn_level[1], btn_press[1], btn_release[1], btn_long[1]});
      end
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_clean edge=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
    btn_in = 2'b11;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_clean_settle k=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  task automatic test_bounce();
    int n_press;
    n_press = 0;
    for (int i = 0; i < 12; i++) begin
      btn_in[0] = i[0];
      repeat (5) begin
        @(negedge clk);
        if (btn_press[0] === 1'b1) n_press++;
        vectors++;
        if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
          miscompares++;
          $display("FAIL model_bounce seg=%0d got %b want %b", i, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
        end
      end
    end
    vectors++;
    if (n_press != 0) begin
      miscompares++;
      $display("FAIL bounce_rejected got %0d presses want 0", n_press);
    end
    btn_in[0] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      vectors++;
      if (btn_press[0] !== (k == 9)) begin
        miscompares++;
        $display("FAIL bounce_final_press edge=%0d got %b want %b", k, btn_press[0], k == 9);
      end
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_bounce_hold edge=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
    btn_in = 2'b11;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_bounce_settle k=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  // Press ch1 and release the raw pin after observing edge rel_k; then check
  // the press/long/release edge numbers against the expected ones.
  task automatic run_ch1_hold(input string tag, input int rel_k, input int last_k,
                              input int exp_rel, input int exp_long);
    int n_press, n_long, n_rel, k_press, k_long, k_rel;
    n_press = 0; n_long = 0; n_rel = 0; k_press = -1; k_long = -1; k_rel = -1;
    btn_in = 2'b01;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (btn_press[1]   === 1'b1) begin n_press++; k_press = k; end
      if (btn_long[1]    === 1'b1) begin n_long++;  k_long  = k; end
      if (btn_release[1] === 1'b1) begin n_rel++;   k_rel   = k; end
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_%s edge=%0d got %b want %b", tag, k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
      if (k == rel_k) btn_in = 2'b11;
    end
    vectors++;
    if (n_press != 1 || k_press != 9) begin
      miscompares++;
      $display("FAIL %s_press got count=%0d edge=%0d want count=1 edge=9", tag, n_press, k_press);
    end
    vectors++;
    if (n_long != ((exp_long >= 0) ? 1 : 0) || k_long != exp_long) begin
      miscompares++;
      $display("FAIL %s_long got count=%0d edge=%0d want edge=%0d", tag, n_long, k_long, exp_long);
    end
    vectors++;
    if (n_rel != 1 || k_rel != exp_rel) begin
      miscompares++;
      $display("FAIL %s_release got count=%0d edge=%0d want count=1 edge=%0d", tag, n_rel, k_rel, exp_rel);
    end
  endtask

  task automatic test_long_press();
    run_ch1_hold("long", 39, 70, 49, 29);
  endtask

  task automatic test_short_press();
    run_ch1_hold("short", 14, 50, 24, -1);
  endtask

  task automatic test_reset_mid();
    int n_rel;
    n_rel  = 0;
    btn_in = 2'b10;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_midreset_pre edge=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_immediate_clear got %b want 00000000", {btn_level, btn_press, btn_release, btn_long});
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 8'h00) begin
        miscompares++;
        $display("FAIL midreset_held got %b want 00000000", {btn_level, btn_press, btn_release, btn_long});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (btn_release[0] === 1'b1) n_rel++;
      vectors++;
      if (btn_press[0] !== (k == 9) || btn_long[0] !== (k == 29)) begin
        miscompares++;
        $display("FAIL midreset_repress edge=%0d got press=%b long=%b want press=%b long=%b", k, btn_press[0], btn_long[0], k == 9, k == 29);
      end
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_midreset_post edge=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
    vectors++;
    if (n_rel != 0) begin
      miscompares++;
      $display("FAIL midreset_no_release got %0d release pulses want 0", n_rel);
    end
    btn_in = 2'b11;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_midreset_settle k=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  task automatic test_random();
    int hold [CH];
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_random n=%0d got %b want %b", n, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                   : int'($urandom_range(1, 12));
        end else begin
          hold[c]--;
        end
      end
    end
    btn_in = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_rel, m_long}) begin
        miscompares++;
        $display("FAIL model_random_settle k=%0d got %b want %b", k, {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_rel, m_long});
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    btn_in      = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
